// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding from EX/MEM and MEM/WB, and load-use
// hazard detection. The forwarded operands feed the ALU combinationally.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_aluctrl,
  input  logic              id_alusrc,
  input  logic              id_regdst,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_memtoreg,
  input  logic              exmem_regwrite,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_regwrite,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_opa,
  output logic [DATA_W-1:0] ex_opb,
  output logic [CTRL_W-1:0] ex_aluctrl,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_dest,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_memtoreg,
  output logic              load_use_stall
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] imm;
    logic [CTRL_W-1:0] aluctrl;
    logic              alusrc;
    logic              regdst;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic              memtoreg;
  } stage_t;

  stage_t stage_q;
  stage_t stage_d;

  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

  // EX/MEM is the younger producer, so it wins over MEM/WB; register 0 is hard-wired.
  function automatic logic [DATA_W-1:0] forward_operand(
    input logic [REG_AW-1:0] src,
    input logic [DATA_W-1:0] latched,
    input logic              em_we,
    input logic [REG_AW-1:0] em_rd,
    input logic [DATA_W-1:0] em_res,
    input logic              mw_we,
    input logic [REG_AW-1:0] mw_rd,
    input logic [DATA_W-1:0] mw_res
  );
    logic [DATA_W-1:0] result;
    result = latched;
    if (em_we && (em_rd != '0) && (em_rd == src)) begin
      result = em_res;
    end else if (mw_we && (mw_rd != '0) && (mw_rd == src)) begin
      result = mw_res;
    end
    return result;
  endfunction

  always_comb begin
    ex_valid    = stage_q.valid;
    ex_aluctrl  = stage_q.aluctrl;
    ex_regwrite = stage_q.regwrite;
    ex_memread  = stage_q.memread;
    ex_memwrite = stage_q.memwrite;
    ex_memtoreg = stage_q.memtoreg;
    ex_dest     = stage_q.regdst ? stage_q.rd : stage_q.rt;
  end

  always_comb begin
    fwd_rs = forward_operand(stage_q.rs, stage_q.rdata1,
                             exmem_regwrite, exmem_rd, exmem_result,
                             memwb_regwrite, memwb_rd, memwb_result);
    fwd_rt = forward_operand(stage_q.rt, stage_q.rdata2,
                             exmem_regwrite, exmem_rd, exmem_result,
                             memwb_regwrite, memwb_rd, memwb_result);
    ex_opa        = fwd_rs;
    ex_store_data = fwd_rt;
    ex_opb        = stage_q.alusrc ? stage_q.imm : fwd_rt;
  end

  always_comb begin
    load_use_stall = stage_q.valid && stage_q.memread && (ex_dest != '0) && id_valid &&
                     ((ex_dest == id_rs) || (ex_dest == id_rt));
  end

  // A stall must keep a pending load-use bubble out, so it is checked before the hazard.
  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = '0;
    end else if (stall) begin
      stage_d = stage_q;
    end else if (load_use_stall) begin
      stage_d = '0;
    end else begin
      stage_d.valid    = id_valid;
      stage_d.rs       = id_rs;
      stage_d.rt       = id_rt;
      stage_d.rd       = id_rd;
      stage_d.rdata1   = id_rdata1;
      stage_d.rdata2   = id_rdata2;
      stage_d.imm      = id_imm;
      stage_d.aluctrl  = id_aluctrl;
      stage_d.alusrc   = id_alusrc;
      stage_d.regdst   = id_regdst;
      stage_d.regwrite = id_regwrite & id_valid;
      stage_d.memread  = id_memread  & id_valid;
      stage_d.memwrite = id_memwrite & id_valid;
      stage_d.memtoreg = id_memtoreg & id_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus pushes expected outputs tagged with a cycle
// number, and a negedge monitor pops and compares them against the DUT.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall, flush, id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rdata1, id_rdata2, id_imm;
  logic [3:0]  id_aluctrl;
  logic        id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg;
  logic        exmem_regwrite, memwb_regwrite;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        ex_valid;
  logic [31:0] ex_opa, ex_opb, ex_store_data;
  logic [3:0]  ex_aluctrl;
  logic [4:0]  ex_dest;
  logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, load_use_stall;

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .CTRL_W(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_aluctrl(id_aluctrl),
    .id_alusrc(id_alusrc), .id_regdst(id_regdst), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .ex_opa(ex_opa), .ex_opb(ex_opb), .ex_aluctrl(ex_aluctrl),
    .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
    .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  typedef enum {S_VALID, S_OPA, S_OPB, S_ALUCTRL, S_STORE, S_DEST,
                S_REGWRITE, S_MEMREAD, S_MEMWRITE, S_MEMTOREG, S_LUS} sel_e;

  typedef struct {
    int          cyc;
    sel_e        sel;
    logic [31:0] value;
    string       name;
  } expect_t;

  expect_t expQ[$];
  int      cyc = 0;
  int      checks = 0;
  int      passes = 0;
  bit      done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actualOf(input sel_e s);
    case (s)
      S_VALID:    return {31'd0, ex_valid};
      S_OPA:      return ex_opa;
      S_OPB:      return ex_opb;
      S_ALUCTRL:  return {28'd0, ex_aluctrl};
      S_STORE:    return ex_store_data;
      S_DEST:     return {27'd0, ex_dest};
      S_REGWRITE: return {31'd0, ex_regwrite};
      S_MEMREAD:  return {31'd0, ex_memread};
      S_MEMWRITE: return {31'd0, ex_memwrite};
      S_MEMTOREG: return {31'd0, ex_memtoreg};
      default:    return {31'd0, load_use_stall};
    endcase
  endfunction

  task automatic checkOutput(input expect_t e);
    logic [31:0] act;
    act = actualOf(e.sel);
    checks++;
    if (act === e.value) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s (cycle %0d): got 0x%08h expected 0x%08h", e.name, e.cyc, act, e.value);
    end
  endtask

  // Monitor: every negedge, drain the expectations tagged for the current cycle.
  always @(negedge clk) begin
    while (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
      checkOutput(expQ.pop_front());
    end
  end

  task automatic expectOut(input sel_e s, input logic [31:0] v, input string name);
    expect_t e;
    e.cyc   = cyc;
    e.sel   = s;
    e.value = v;
    e.name  = name;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic setId(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] imm, input logic [3:0] ctrl, input logic asrc,
                       input logic rdst, input logic rw, input logic mr, input logic mw,
                       input logic m2r);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rdata1 = r1; id_rdata2 = r2; id_imm = imm; id_aluctrl = ctrl;
    id_alusrc = asrc; id_regdst = rdst; id_regwrite = rw;
    id_memread = mr; id_memwrite = mw; id_memtoreg = m2r;
  endtask

  task automatic setFwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                        input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
    exmem_regwrite = ew; exmem_rd = erd; exmem_result = eres;
    memwb_regwrite = mw; memwb_rd = mrd; memwb_result = mres;
  endtask

  initial begin
    stall = 1'b0; flush = 1'b0;
    setId(0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    setFwd(0, 0, 0, 0, 0, 0);

    applyStimulus();
    expectOut(S_VALID, 0, "reset_valid");
    expectOut(S_ALUCTRL, 0, "reset_aluctrl");
    expectOut(S_OPA, 0, "reset_opa");
    expectOut(S_REGWRITE, 0, "reset_regwrite");

    applyStimulus();
    rst = 1'b0;
    setId(1, 1, 2, 4, 32'd5, 32'd7, 32'd0, 4'b0010, 0, 1, 1, 0, 0, 0);

    applyStimulus();
    stall = 1'b1;
    setId(0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    expectOut(S_VALID, 1, "load_valid");
    expectOut(S_OPA, 32'd5, "load_opa");
    expectOut(S_OPB, 32'd7, "load_opb");
    expectOut(S_ALUCTRL, 4'b0010, "load_aluctrl");
    expectOut(S_DEST, 5'd4, "load_dest_rd");
    expectOut(S_REGWRITE, 1, "load_regwrite");

    applyStimulus();
    setFwd(1, 1, 32'd9, 1, 1, 32'd4);
    expectOut(S_OPA, 32'd9, "fwd_exmem_priority");
    expectOut(S_OPB, 32'd7, "fwd_rt_unmatched");
    expectOut(S_VALID, 1, "stall_holds_valid");

    applyStimulus();
    setFwd(1, 0, 32'd9, 1, 0, 32'd4);
    expectOut(S_OPA, 32'd5, "fwd_r0_blocked");

    applyStimulus();
    setFwd(0, 1, 32'd9, 1, 1, 32'd4);
    expectOut(S_OPA, 32'd4, "fwd_memwb");

    applyStimulus();
    stall = 1'b0;
    setFwd(0, 0, 0, 0, 0, 0);
    setId(1, 0, 3, 0, 32'd0, 32'd0, 32'd8, 4'b0010, 1, 0, 1, 1, 0, 1);
    expectOut(S_VALID, 1, "pre_load_valid");
    expectOut(S_LUS, 0, "no_hazard_lus");

    applyStimulus();
    setId(1, 3, 5, 6, 32'd100, 32'd200, 32'd0, 4'b0110, 0, 1, 1, 0, 0, 0);
    expectOut(S_MEMREAD, 1, "lw_memread");
    expectOut(S_DEST, 5'd3, "lw_dest_rt");
    expectOut(S_OPB, 32'd8, "lw_opb_imm");
    expectOut(S_MEMTOREG, 1, "lw_memtoreg");
    expectOut(S_LUS, 1, "lus_asserted");

    applyStimulus();
    expectOut(S_VALID, 0, "bubble_valid");
    expectOut(S_REGWRITE, 0, "bubble_regwrite");
    expectOut(S_MEMREAD, 0, "bubble_memread");
    expectOut(S_LUS, 0, "lus_released");

    applyStimulus();
    setId(0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    setFwd(0, 0, 0, 1, 3, 32'd55);
    expectOut(S_VALID, 1, "held_instr_valid");
    expectOut(S_DEST, 5'd6, "held_instr_dest");
    expectOut(S_OPA, 32'd55, "held_instr_fwd_opa");
    expectOut(S_OPB, 32'd200, "held_instr_opb");
    expectOut(S_ALUCTRL, 4'b0110, "held_instr_aluctrl");

    applyStimulus();
    setFwd(0, 0, 0, 0, 0, 0);
    setId(1, 0, 3, 0, 32'd0, 32'd0, 32'd8, 4'b0010, 1, 0, 1, 1, 0, 1);
    expectOut(S_VALID, 0, "idle_valid");

    applyStimulus();
    stall = 1'b1;
    setId(1, 3, 5, 6, 32'd100, 32'd200, 32'd0, 4'b0110, 0, 1, 1, 0, 0, 0);
    expectOut(S_LUS, 1, "lus_before_stall");

    applyStimulus();
    flush = 1'b1;
    expectOut(S_VALID, 1, "stall_over_lus_valid");
    expectOut(S_MEMREAD, 1, "stall_over_lus_memread");
    expectOut(S_DEST, 5'd3, "stall_over_lus_dest");

    applyStimulus();
    flush = 1'b0;
    stall = 1'b0;
    setId(1, 7, 8, 0, 32'h21, 32'd11, 32'hFFFF_FFFC, 4'b0000, 1, 0, 0, 0, 1, 0);
    expectOut(S_VALID, 0, "flush_valid");
    expectOut(S_MEMREAD, 0, "flush_memread");
    expectOut(S_DEST, 0, "flush_dest");
    expectOut(S_LUS, 0, "flush_lus");

    applyStimulus();
    stall = 1'b1;
    setId(0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    setFwd(1, 8, 32'h1234, 0, 0, 0);
    expectOut(S_OPB, 32'hFFFF_FFFC, "alusrc_opb_imm");
    expectOut(S_STORE, 32'h1234, "store_data_fwd");
    expectOut(S_OPA, 32'h21, "store_opa");
    expectOut(S_MEMWRITE, 1, "store_memwrite");

    applyStimulus();
    rst = 1'b1;
    setFwd(0, 0, 0, 0, 0, 0);
    expectOut(S_VALID, 0, "async_reset_valid");
    expectOut(S_MEMWRITE, 0, "async_reset_memwrite");
    expectOut(S_ALUCTRL, 0, "async_reset_aluctrl");
    expectOut(S_OPB, 0, "async_reset_opb");
    expectOut(S_STORE, 0, "async_reset_store");

    applyStimulus();
    rst = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      checks++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
    end
    done = 1'b1;
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #5000;
    if (!done) begin
      $display("[TB] FAIL timeout: got no completion expected completion");
      $fatal(1, "[TB] timeout");
    end
  end

endmodule
